// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state controller (IDLE/REQ/HALT) that issues one
// instruction-memory read per fetch request, tracks the PC, applies branches and times out stalled reads.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        fetch_req,
  input  logic        br_taken,
  input  logic        br_rel,
  input  logic [15:0] br_addr,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [3:0]  opcode,
  output logic [3:0]  mm,
  output logic [15:0] pc,
  output logic        instr_vld,
  output logic        busy,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        mem_rd_q, mem_rd_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        instr_vld_q, instr_vld_d;
  logic        fetch_err_q, fetch_err_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_tgt_q, pend_tgt_d;

  logic [15:0] br_tgt;
  logic        timeout;
  logic        pend_hit;
  logic [15:0] pend_sel;

  // Relative offsets are 16-bit two's complement, so a plain 16-bit add both
  // sign-extends and wraps modulo 2^16.
  assign br_tgt = br_rel ? (pc_q + br_addr) : br_addr;

  // The 16th consecutive REQ cycle without an acknowledge aborts the read;
  // an acknowledge in that same cycle still wins.
  assign timeout = (state_q == ST_REQ) && !mem_ack && (wait_cnt_q == 4'hF);

  // A branch arriving in the very cycle a read resolves is newer than any held one.
  assign pend_hit = pend_vld_q | br_taken;
  assign pend_sel = br_taken ? br_tgt : pend_tgt_q;

  // State register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = (mem_rdata[31:28] == 4'hF) ? ST_HALT : ST_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy   = (state_q == ST_REQ);
    halted = (state_q == ST_HALT);
  end

  // Datapath next-state
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    instr_vld_d = 1'b0;
    fetch_err_d = fetch_err_q;
    wait_cnt_d  = wait_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (br_taken) begin
          pc_d = br_tgt;
        end
        if (fetch_req) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = br_taken ? br_tgt : pc_q;
          wait_cnt_d = 4'd0;
          pend_vld_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          instr_d     = mem_rdata;
          pc_d        = pend_hit ? pend_sel : (pc_q + 16'd1);
          mem_rd_d    = 1'b0;
          instr_vld_d = 1'b1;
          pend_vld_d  = 1'b0;
        end else if (timeout) begin
          fetch_err_d = 1'b1;
          mem_rd_d    = 1'b0;
          pc_d        = pend_hit ? pend_sel : pc_q;
          pend_vld_d  = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
          pend_vld_d = pend_hit;
          pend_tgt_d = pend_sel;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_q        <= 16'h0000;
      instr_q     <= 32'h0000_0000;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      instr_vld_q <= 1'b0;
      fetch_err_q <= 1'b0;
      wait_cnt_q  <= 4'd0;
      pend_vld_q  <= 1'b0;
      pend_tgt_q  <= 16'h0000;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      instr_vld_q <= instr_vld_d;
      fetch_err_q <= fetch_err_d;
      wait_cnt_q  <= wait_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  assign pc        = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:28];
  assign mm        = instr_q[27:24];
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign instr_vld = instr_vld_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of per-cycle vectors plus
// hand-written sequences for timeout, pending-branch and asynchronous reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        fetch_req;
  logic        br_taken;
  logic        br_rel;
  logic [15:0] br_addr;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc;
  logic        instr_vld;
  logic        busy;
  logic        halted;
  logic        fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .fetch_req (fetch_req),
    .br_taken  (br_taken),
    .br_rel    (br_rel),
    .br_addr   (br_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .instr     (instr),
    .opcode    (opcode),
    .mm        (mm),
    .pc        (pc),
    .instr_vld (instr_vld),
    .busy      (busy),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic        bt;
    logic        brl;
    logic [15:0] ba;
    logic        ack;
    logic [31:0] rd;
    logic        e_rd;
    logic [15:0] e_addr;
    logic [15:0] e_pc;
    logic [31:0] e_instr;
    logic        e_vld;
    logic        e_busy;
    logic        e_halt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic bt, input logic brl,
                       input logic [15:0] ba, input logic ack, input logic [31:0] rd);
    fetch_req = fr;
    br_taken  = bt;
    br_rel    = brl;
    br_addr   = ba;
    mem_ack   = ack;
    mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 16'h0, 0, 32'h0);
    rst_f = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_f = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    drive(0, 0, 0, 16'h0, 0, 32'h0);
    rst_f = 1'b0;
    #1;
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_flags", {28'd0, instr_vld, busy, halted, fetch_err}, 32'd0);
    $display("reset: pc=%h instr=%h mem_rd=%b", pc, instr, mem_rd);
    @(negedge clk);
    @(negedge clk);
    rst_f = 1'b1;

    //                fr bt brl ba        ack rd            e_rd e_addr   e_pc     e_instr       vld busy halt err
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 32'h0,         0, 16'h0000, 16'h0000, 32'h0,         0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 16'h0000, 0, 32'h0,         1, 16'h0000, 16'h0000, 32'h0,         0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 32'h8100_0001, 0, 16'h0000, 16'h0001, 32'h8100_0001, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 32'h0,         0, 16'h0000, 16'h0001, 32'h8100_0001, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0010, 0, 32'h0,         0, 16'h0000, 16'h0010, 32'h8100_0001, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 16'hFFF0, 0, 32'h0,         0, 16'h0000, 16'h0000, 32'h8100_0001, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0042, 0, 32'h0,         0, 16'h0000, 16'h0042, 32'h8100_0001, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 16'h0200, 0, 32'h0,         1, 16'h0200, 16'h0200, 32'h8100_0001, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 16'h0000, 0, 32'h0,         1, 16'h0200, 16'h0200, 32'h8100_0001, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0100, 0, 32'h0,         1, 16'h0200, 16'h0200, 32'h8100_0001, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 1, 16'h0005, 0, 32'h0,         1, 16'h0200, 16'h0200, 32'h8100_0001, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 32'h1234_5678, 0, 16'h0200, 16'h0205, 32'h1234_5678, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 32'hAAAA_AAAA, 0, 16'h0200, 16'h0205, 32'h1234_5678, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 16'hFFFF, 0, 32'h0,         0, 16'h0200, 16'hFFFF, 32'h1234_5678, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 16'h0000, 0, 32'h0,         1, 16'hFFFF, 16'hFFFF, 32'h1234_5678, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 32'h2000_0000, 0, 16'hFFFF, 16'h0000, 32'h2000_0000, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 16'h0000, 0, 32'h0,         1, 16'h0000, 16'h0000, 32'h2000_0000, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 32'hF000_0000, 0, 16'h0000, 16'h0001, 32'hF000_0000, 1, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 16'h0300, 0, 32'h0,         0, 16'h0000, 16'h0001, 32'hF000_0000, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 32'h1111_1111, 0, 16'h0000, 16'h0001, 32'hF000_0000, 0, 0, 1, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.fr, v.bt, v.brl, v.ba, v.ack, v.rd);
      step();
      chk($sformatf("v%0d_mem_rd", i), {31'd0, mem_rd}, {31'd0, v.e_rd});
      chk($sformatf("v%0d_mem_addr", i), {16'd0, mem_addr}, {16'd0, v.e_addr});
      chk($sformatf("v%0d_pc", i), {16'd0, pc}, {16'd0, v.e_pc});
      chk($sformatf("v%0d_instr", i), instr, v.e_instr);
      chk($sformatf("v%0d_opcode_mm", i), {24'd0, opcode, mm}, {24'd0, v.e_instr[31:24]});
      chk($sformatf("v%0d_flags", i), {28'd0, instr_vld, busy, halted, fetch_err},
          {28'd0, v.e_vld, v.e_busy, v.e_halt, v.e_err});
      $display("vec %0d: fr=%b bt=%b ack=%b -> mem_rd=%b addr=%h pc=%h instr=%h vld=%b busy=%b halt=%b err=%b",
               i, v.fr, v.bt, v.ack, mem_rd, mem_addr, pc, instr, instr_vld, busy, halted, fetch_err);
    end

    // Timeout after 16 un-acknowledged REQ cycles, pending branch applied to pc
    do_reset();
    drive(1, 0, 0, 16'h0, 0, 32'h0);
    step();
    for (int i = 1; i <= 16; i++) begin
      drive(0, (i == 1), 0, 16'h0300, 0, 32'h0);
      step();
      if (i < 16) begin
        chk($sformatf("to_wait%0d_mem_rd", i), {31'd0, mem_rd}, 32'd1);
      end
    end
    chk("to_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_pc", {16'd0, pc}, 32'h0300);
    chk("to_vld_busy", {30'd0, instr_vld, busy}, 32'd0);
    chk("to_instr", instr, 32'd0);
    $display("timeout: mem_rd=%b err=%b pc=%h", mem_rd, fetch_err, pc);
    drive(0, 0, 0, 16'h0, 0, 32'h0);
    step();
    chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);

    // Acknowledge arriving on the 16th wait cycle completes normally
    do_reset();
    drive(1, 0, 0, 16'h0, 0, 32'h0);
    step();
    for (int i = 1; i <= 15; i++) begin
      drive(0, 0, 0, 16'h0, 0, 32'h0);
      step();
    end
    chk("ack16_mem_rd_before", {31'd0, mem_rd}, 32'd1);
    drive(0, 0, 0, 16'h0, 1, 32'h3300_0007);
    step();
    chk("ack16_err", {31'd0, fetch_err}, 32'd0);
    chk("ack16_vld", {31'd0, instr_vld}, 32'd1);
    chk("ack16_pc", {16'd0, pc}, 32'h0001);
    chk("ack16_instr", instr, 32'h3300_0007);
    chk("ack16_mem_rd", {31'd0, mem_rd}, 32'd0);
    $display("ack16: err=%b vld=%b pc=%h instr=%h", fetch_err, instr_vld, pc, instr);

    // Asynchronous reset in the middle of a read
    drive(1, 0, 0, 16'h0, 0, 32'h0);
    step();
    chk("ar_mem_rd_pre", {31'd0, mem_rd}, 32'd1);
    chk("ar_addr_pre", {16'd0, mem_addr}, 32'h0001);
    drive(0, 0, 0, 16'h0, 0, 32'h0);
    #2;
    rst_f = 1'b0;
    #1;
    chk("ar_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("ar_pc", {16'd0, pc}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_instr", instr, 32'd0);
    $display("async reset: mem_rd=%b pc=%h busy=%b", mem_rd, pc, busy);
    @(negedge clk);
    rst_f = 1'b1;
    drive(0, 0, 0, 16'h0, 1, 32'h4400_0000);
    step();
    chk("ar_late_ack_vld", {31'd0, instr_vld}, 32'd0);
    chk("ar_late_ack_instr", instr, 32'd0);
    drive(1, 0, 0, 16'h0, 0, 32'h0);
    step();
    chk("ar_first_addr", {16'd0, mem_addr}, 32'd0);
    chk("ar_first_rd", {31'd0, mem_rd}, 32'd1);
    $display("post reset fetch: mem_rd=%b addr=%h", mem_rd, mem_addr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
